// File: rtl/mcpu_intc_pkg.sv
// Shared definitions for the MCPU interrupt controller: register offsets,
// delivery FSM states and the source-count ceiling.
package mcpu_intc_pkg;

  localparam int INTC_NSRC_MAX = 16;

  localparam logic [1:0] INTC_STATUS = 2'd0;
  localparam logic [1:0] INTC_ENABLE = 2'd1;
  localparam logic [1:0] INTC_MODE   = 2'd2;
  localparam logic [1:0] INTC_CLEAR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_ACK
  } intc_state_e;

endpackage

// File: rtl/mcpu_intc_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending vector.
module mcpu_intc_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [3:0]      idx
);

  // Scan from the top down so the lowest set index is the last to overwrite idx.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/mcpu_intc.sv
// MCPU interrupt controller: source aggregation, bus registers and pending/clear
// handshake to the core. Define MCPU_INTC_EDGE_EN to build edge-mode sources.
module mcpu_intc
  import mcpu_intc_pkg::*;
#(
  parameter int                         NSRC       = 8,
  parameter logic [INTC_NSRC_MAX-1:0]   RST_ENABLE = '0
) (
  input  logic            clkrst_core_clk,
  input  logic            clkrst_core_rst,
  input  logic [NSRC-1:0] int_src,
  input  logic [1:0]      periph_addr,
  input  logic            periph_sel,
  input  logic            periph_re,
  input  logic [3:0]      periph_we,
  input  logic [31:0]     periph_data_in,
  output logic [31:0]     periph_data_out,
  output logic            int_pending,
  output logic [3:0]      int_type,
  input  logic            int_clear
);

  intc_state_e     state;
  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mode_rd;
  logic [31:0]     wmask;
  logic [NSRC-1:0] bmask;
  logic [NSRC-1:0] wbits;
  logic [31:0]     rdata;
  logic            any;
  logic [3:0]      idx;
  logic            unused_bits;

  assign wmask = {{8{periph_we[3]}}, {8{periph_we[2]}}, {8{periph_we[1]}}, {8{periph_we[0]}}};
  assign bmask = wmask[NSRC-1:0];
  assign wbits = periph_data_in[NSRC-1:0];
  assign unused_bits = ^{wmask, periph_data_in};

`ifdef MCPU_INTC_EDGE_EN
  logic [NSRC-1:0] mode_q;
  logic [NSRC-1:0] latch_q;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] clr_wr;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = (state == ST_PEND) && int_clear && (int_type == 4'(i));
    end
  end

  assign clr_wr  = (periph_sel && periph_addr == INTC_CLEAR) ? (wbits & bmask) : '0;
  assign pend    = (int_src & ~mode_q) | (latch_q & mode_q);
  assign mode_rd = mode_q;

  // A rising edge on an edge-mode source beats any clear landing the same cycle.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      mode_q  <= '0;
      latch_q <= '0;
      src_q   <= '0;
    end else begin
      src_q   <= int_src;
      latch_q <= (latch_q & ~(clr_wr | ack_clr)) | (int_src & ~src_q & mode_q);
      if (periph_sel && periph_addr == INTC_MODE)
        mode_q <= (mode_q & ~bmask) | (wbits & bmask);
    end
  end
`else
  assign pend    = int_src;
  assign mode_rd = '0;
`endif

  mcpu_intc_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req (pend & enable_q),
    .any (any),
    .idx (idx)
  );

  always_comb begin
    rdata = '0;
    case (periph_addr)
      INTC_STATUS: rdata = 32'(pend);
      INTC_ENABLE: rdata = 32'(enable_q);
      INTC_MODE:   rdata = 32'(mode_rd);
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      enable_q        <= RST_ENABLE[NSRC-1:0];
      periph_data_out <= '0;
    end else begin
      if (periph_sel && periph_addr == INTC_ENABLE)
        enable_q <= (enable_q & ~bmask) | (wbits & bmask);
      periph_data_out <= (periph_sel && periph_re) ? rdata : '0;
    end
  end

  // Once delivered, the interrupt stays up until acknowledged, whatever the
  // source or enable does; ACK gives one quiet cycle before re-arbitration.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state       <= ST_IDLE;
      int_pending <= 1'b0;
      int_type    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            state       <= ST_PEND;
            int_pending <= 1'b1;
            int_type    <= idx;
          end
        end
        ST_PEND: begin
          if (int_clear) begin
            state       <= ST_ACK;
            int_pending <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          int_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_intc.sv
// Randomized and directed bench for mcpu_intc against a per-source behavioural
// model; honours MCPU_INTC_EDGE_EN the same way the design does.
module tb_mcpu_intc;

  localparam int          NSRC   = 8;
  localparam logic [15:0] RST_EN = 16'h005A;
`ifdef MCPU_INTC_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic            clkrst_core_clk = 1'b0;
  logic            clkrst_core_rst;
  logic [NSRC-1:0] int_src;
  logic [1:0]      periph_addr;
  logic            periph_sel;
  logic            periph_re;
  logic [3:0]      periph_we;
  logic [31:0]     periph_data_in;
  logic [31:0]     periph_data_out;
  logic            int_pending;
  logic [3:0]      int_type;
  logic            int_clear;

  int checks = 0;
  int errors = 0;

  bit [NSRC-1:0] m_enable, m_mode, m_latch, m_prev;
  int            m_phase;
  int            m_type;
  logic [31:0]   exp_data;
  bit            exp_pending;

  always #5 clkrst_core_clk = ~clkrst_core_clk;

  mcpu_intc #(.NSRC(NSRC), .RST_ENABLE(RST_EN)) dut (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .int_src         (int_src),
    .periph_addr     (periph_addr),
    .periph_sel      (periph_sel),
    .periph_re       (periph_re),
    .periph_we       (periph_we),
    .periph_data_in  (periph_data_in),
    .periph_data_out (periph_data_out),
    .int_pending     (int_pending),
    .int_type        (int_type),
    .int_clear       (int_clear)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Behavioural model: one pass per clock using this cycle's inputs.
  task automatic modelStep();
    bit [NSRC-1:0] pendv;
    bit [NSRC-1:0] nlatch;
    bit            rise;
    bit            clr;
    int            pick;
    if (clkrst_core_rst) begin
      m_enable = RST_EN[NSRC-1:0];
      m_mode   = '0;
      m_latch  = '0;
      m_prev   = '0;
      m_phase  = 0;
      m_type   = 0;
      exp_data = '0;
    end else begin
      for (int i = 0; i < NSRC; i++)
        pendv[i] = (EDGE_EN && m_mode[i]) ? m_latch[i] : int_src[i];
      exp_data = '0;
      if (periph_sel && periph_re) begin
        case (periph_addr)
          2'd0: exp_data = 32'(pendv);
          2'd1: exp_data = 32'(m_enable);
          2'd2: exp_data = EDGE_EN ? 32'(m_mode) : 32'd0;
          default: exp_data = '0;
        endcase
      end
      pick = -1;
      for (int i = NSRC - 1; i >= 0; i--)
        if (pendv[i] && m_enable[i]) pick = i;
      for (int i = 0; i < NSRC; i++) begin
        rise = m_mode[i] && int_src[i] && !m_prev[i];
        clr  = (periph_sel && periph_addr == 2'd3 && periph_we[i/8] && periph_data_in[i]) ||
               (m_phase == 1 && int_clear && m_type == i);
        nlatch[i] = rise ? 1'b1 : (clr ? 1'b0 : m_latch[i]);
      end
      if (EDGE_EN) m_latch = nlatch;
      case (m_phase)
        0: if (pick >= 0) begin m_phase = 1; m_type = pick; end
        1: if (int_clear) m_phase = 2;
        default: m_phase = 0;
      endcase
      for (int i = 0; i < NSRC; i++) begin
        if (periph_sel && periph_we[i/8]) begin
          if (periph_addr == 2'd1) m_enable[i] = periph_data_in[i];
          if (periph_addr == 2'd2 && EDGE_EN) m_mode[i] = periph_data_in[i];
        end
      end
      m_prev = int_src;
    end
    exp_pending = (m_phase == 1);
  endtask

  // Drives the current inputs for one clock, then checks outputs mid-cycle.
  task automatic applyStimulus();
    modelStep();
    @(negedge clkrst_core_clk);
    checkOutput("int_pending", 32'(int_pending), 32'(exp_pending));
    checkOutput("int_type", 32'(int_type), 32'(m_type));
    checkOutput("data_out", periph_data_out, exp_data);
    periph_sel = 1'b0;
    periph_re  = 1'b0;
    periph_we  = 4'h0;
    int_clear  = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] we);
    periph_sel     = 1'b1;
    periph_addr    = addr;
    periph_we      = we;
    periph_data_in = data;
    applyStimulus();
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] value);
    periph_sel  = 1'b1;
    periph_re   = 1'b1;
    periph_addr = addr;
    applyStimulus();
    value = periph_data_out;
  endtask

  task automatic drain();
    int_src   = '0;
    int_clear = 1'b1;
    repeat (3) applyStimulus();
  endtask

  initial begin
    logic [31:0] v;
    int r;
    clkrst_core_rst = 1'b1;
    int_src = '0;
    periph_addr = '0;
    periph_sel = 1'b0;
    periph_re = 1'b0;
    periph_we = 4'h0;
    periph_data_in = '0;
    int_clear = 1'b0;
    @(negedge clkrst_core_clk);
    repeat (2) applyStimulus();
    clkrst_core_rst = 1'b0;
    checkOutput("rst_pending", 32'(int_pending), 32'd0);
    busRead(2'd1, v);
    checkOutput("rst_enable", v, 32'h5A);

    $display("[TB] level source 5");
    busWrite(2'd1, 32'hFF, 4'hF);
    int_src = 8'h20;
    applyStimulus();
    checkOutput("lvl_rise", 32'(int_pending), 32'd1);
    checkOutput("lvl_type", 32'(int_type), 32'd5);
    int_clear = 1'b1;
    applyStimulus();
    checkOutput("lvl_ack_low", 32'(int_pending), 32'd0);
    applyStimulus();
    checkOutput("lvl_idle_low", 32'(int_pending), 32'd0);
    applyStimulus();
    checkOutput("lvl_reassert", 32'(int_pending), 32'd1);
    checkOutput("lvl_retype", 32'(int_type), 32'd5);
    drain();

`ifdef MCPU_INTC_EDGE_EN
    $display("[TB] edge source 2");
    busWrite(2'd2, 32'h04, 4'hF);
    int_src = 8'h04;
    applyStimulus();
    checkOutput("edge_t1_low", 32'(int_pending), 32'd0);
    int_src = 8'h00;
    busRead(2'd0, v);
    checkOutput("edge_status", v, 32'h04);
    checkOutput("edge_t2_high", 32'(int_pending), 32'd1);
    checkOutput("edge_type", 32'(int_type), 32'd2);
    int_clear = 1'b1;
    applyStimulus();
    busRead(2'd0, v);
    checkOutput("edge_status_clr", v, 32'h00);
    busWrite(2'd2, 32'h00, 4'hF);
`else
    busWrite(2'd2, 32'hFF, 4'hF);
    busRead(2'd2, v);
    checkOutput("mode_absent", v, 32'h00);
`endif

    $display("[TB] priority 3 over 6");
    int_src = 8'h48;
    applyStimulus();
    checkOutput("prio_first", 32'(int_type), 32'd3);
    int_src = 8'h40;
    int_clear = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("prio_second_pend", 32'(int_pending), 32'd1);
    checkOutput("prio_second", 32'(int_type), 32'd6);
    drain();

    $display("[TB] enable gating");
    busWrite(2'd1, 32'h00, 4'hF);
    int_src = 8'hFF;
    repeat (2) applyStimulus();
    checkOutput("gated_low", 32'(int_pending), 32'd0);
    busRead(2'd0, v);
    checkOutput("gated_status", v, 32'hFF);
    busWrite(2'd1, 32'h80, 4'hF);
    applyStimulus();
    checkOutput("en7_pend", 32'(int_pending), 32'd1);
    checkOutput("en7_type", 32'(int_type), 32'd7);
    busWrite(2'd1, 32'hFFFFFF00, 4'b1110);
    busRead(2'd1, v);
    checkOutput("byte_en", v, 32'h80);
    drain();

`ifdef MCPU_INTC_EDGE_EN
    $display("[TB] clear vs edge collision");
    busWrite(2'd1, 32'h00, 4'hF);
    busWrite(2'd2, 32'h02, 4'hF);
    int_src = 8'h02;
    applyStimulus();
    int_src = 8'h00;
    applyStimulus();
    int_src = 8'h02;
    busWrite(2'd3, 32'h02, 4'hF);
    busRead(2'd0, v);
    checkOutput("set_wins", v, 32'h02);
    busWrite(2'd3, 32'h02, 4'hF);
    busRead(2'd0, v);
    checkOutput("clr_write", v, 32'h00);
    busRead(2'd3, v);
    checkOutput("clear_reads0", v, 32'h00);
    int_src = 8'h00;
`endif

    $display("[TB] reset during pend");
    busWrite(2'd1, 32'hFF, 4'hF);
    int_src = 8'h10;
    applyStimulus();
    checkOutput("pre_rst_type", 32'(int_type), 32'd4);
    clkrst_core_rst = 1'b1;
    applyStimulus();
    clkrst_core_rst = 1'b0;
    checkOutput("rst_pend_low", 32'(int_pending), 32'd0);
    checkOutput("rst_type0", 32'(int_type), 32'd0);
    int_src = 8'h00;
    busRead(2'd1, v);
    checkOutput("rst_enable2", v, 32'h5A);

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      int_src = int_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      r = $urandom_range(0, 99);
      if (r < 15) begin
        periph_sel     = 1'b1;
        periph_addr    = 2'($urandom);
        periph_we      = 4'($urandom);
        periph_data_in = $urandom;
      end else if (r < 35) begin
        periph_sel  = 1'b1;
        periph_re   = 1'b1;
        periph_addr = 2'($urandom);
      end
      int_clear = ($urandom_range(0, 3) == 0);
      clkrst_core_rst = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    clkrst_core_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcpu_intc.md
# mcpu_intc

Parametrised interrupt controller for the MCPU SoC. It replaces the tied-off interrupt inputs of the core (`int_pending = 0`, `int_type = 0`, `int_clear` unused) with a real source aggregator. It sits on the peripheral bus beside MCPU_SOC_mmio, decoded from the `dl1c2periph_*` signals. It collects up to 16 interrupt sources, each with per-source enable and level/edge mode, and presents the highest-priority one to MCPU_core with a pending/clear handshake.

## Interface
Parameters:
- `NSRC`, 8 — number of interrupt sources, legal range 1..16.
- `RST_ENABLE`, 0 — reset value of the ENABLE register (bits above `NSRC-1` ignored).

Ports:
- `clkrst_core_clk` in 1 — core clock; the only clock.
- `clkrst_core_rst` in 1 — reset, synchronous, active-high.
- `int_src` in NSRC — raw sources, synchronous to `clkrst_core_clk`.
- `periph_addr` in 2 — word offset within the controller, already decoded by the bus.
- `periph_sel` in 1 — controller selected this cycle.
- `periph_re` in 1 — read strobe.
- `periph_we` in 4 — per-byte write enables.
- `periph_data_in` in 32 — write data.
- `periph_data_out` out 32 — read data.
- `int_pending` out 1 — to core.
- `int_type` out 4 — index of the delivered source.
- `int_clear` in 1 — one-cycle acknowledge from core.

## Operation
- Registers (word offsets):
  - 0 STATUS: RO, `pend` vector.
  - 1 ENABLE: RW.
  - 2 MODE: RW, 1 = edge.
  - 3 CLEAR: write-1-to-clear edge latches; reads as 0.
- Only bits `[NSRC-1:0]` are implemented. Other bits read 0 and ignore writes. Byte enables are honoured per byte.
- Source behaviour:
  - Level source: `pend[i] = int_src[i]`.
  - Edge source: `pend[i]` is a latch, set on a rising edge (`int_src & ~src_q`). It is cleared by a CLEAR write or by `int_clear` while `int_type == i`. If set and clear hit the same cycle, set wins.
- `req = pend & ENABLE`. The priority encoder picks the lowest set index.
- FSM:
  - IDLE: if `req != 0`, go to PEND and latch `int_type`.
  - PEND: `int_pending = 1` and `int_type` is held stable. On `int_clear`, go to ACK.
  - ACK: one holdoff cycle with `int_pending = 0`, giving software time to quiesce a level source. Then go to IDLE.
- Clearing ENABLE or the source while in PEND does not withdraw the interrupt; it remains until `int_clear`.
- `int_clear` outside PEND is ignored.

## Timing
- Reset values: `int_pending = 0`, `int_type = 0`, `periph_data_out = 0`, STATUS/latches = 0, ENABLE = `RST_ENABLE`, MODE = 0, `src_q = 0`, FSM = IDLE. Reset applied mid-operation overrides all of these at the next edge.
- Level source high at cycle t, enabled, FSM in IDLE: `int_pending` rises at t+1.
- Edge source rising at cycle t: latch set at t+1, `int_pending` rises at t+2.
- `int_clear` at cycle t: `int_pending` is low at t+1 (ACK). The earliest re-assertion is t+3.
- Reads: `periph_data_out` is valid the cycle after `periph_sel & periph_re`, and is 0 otherwise.
- Writes take effect at the next edge. A register write and a source edge in the same cycle: the write applies to ENABLE/MODE, and the edge latch still sets.

## Configuration
- `MCPU_INTC_EDGE_EN` defined: MODE register, edge latches and the CLEAR register are present, as described above.
- Not defined: all sources are level. MODE and CLEAR read 0 and ignore writes. `src_q` and the latches are removed. Level latency is unchanged.

## Structure
- `mcpu_intc_pkg` holds:
  - register offsets (`INTC_STATUS`, `INTC_ENABLE`, `INTC_MODE`, `INTC_CLEAR`);
  - FSM state enum (IDLE/PEND/ACK);
  - `INTC_NSRC_MAX = 16`.
- Sub-module `mcpu_intc_prio_enc`: `NSRC`-wide lowest-index priority encoder with `any` and 4-bit `idx` outputs.

## Test plan
- NSRC=8, ENABLE=0xFF, level `int_src[5]` held high → `int_pending` rises one cycle later with `int_type = 5`. `int_clear` → one low cycle, then re-asserts with 5.
- Edge mode on bit 2, pulse `int_src[2]` for 1 cycle → STATUS reads 0x04 and `int_pending` rises at t+2. `int_clear` → STATUS reads 0x00.
- Sources 3 and 6 both pending → `int_type = 3`. After clearing it, `int_type = 6`.
- ENABLE=0x00 with all sources high → `int_pending` stays 0 and STATUS reads 0xFF. Writing ENABLE=0x80 → `int_type = 7`.
- Edge latch on bit 1 with a CLEAR write of 0x02 and a new rising edge on bit 1 in the same cycle → the latch stays set.
- Assert reset during PEND → next cycle `int_pending = 0`, `int_type = 0`, ENABLE = `RST_ENABLE`.
